// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DATA_WIDTH_DEF      = 32;
  localparam int unsigned DMEM_ADDR_WIDTH_DEF = 8;
  localparam int unsigned MAX_BURST_DEF       = 4;

  // Port identifiers, used for last_gnt and for the response tag.
  localparam logic C0 = 1'b0;
  localparam logic C1 = 1'b1;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous data memory.
// Port 0 is the core load/store stage; port 1 is the debug/loader master,
// which may hold the memory for a bounded locked burst.
//
// Handshake: a port raises req with its fields and holds them unchanged
// until gnt is seen high in the same cycle; gnt is combinational and the
// access is taken at the next rising edge. Read data returns one cycle
// later on rvalid/rdata of the issuing port; writes return nothing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int P_DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int P_DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
  parameter int P_MAX_BURST       = MAX_BURST_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_c0_req,
  input  logic                         i_c0_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_c0_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_c0_wdata,
  output logic                         o_c0_gnt,
  output logic                         o_c0_stall,
  output logic                         o_c0_rvalid,
  output logic [P_DATA_WIDTH-1:0]      o_c0_rdata,
  input  logic                         i_c1_req,
  input  logic                         i_c1_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_c1_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_c1_wdata,
  input  logic                         i_c1_lock,
  output logic                         o_c1_gnt,
  output logic                         o_c1_rvalid,
  output logic [P_DATA_WIDTH-1:0]      o_c1_rdata,
  output logic [P_DMEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                         o_mem_we,
  output logic [P_DATA_WIDTH-1:0]      o_mem_wdata,
  input  logic [P_DATA_WIDTH-1:0]      i_mem_rdata,
  output arb_state_e                   o_dbg_state
);

  localparam int CNT_W = $clog2(P_MAX_BURST);
  // Count value at which the next port-1 grant is the last one of a burst.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             gnt0, gnt1;

  // Winner selection: locked burst owns the memory, otherwise round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      if (state_q == LOCK1) begin
        gnt1 = i_c1_req;
      end else if (i_c0_req && i_c1_req) begin
        gnt0 = (last_gnt_q == C1);
        gnt1 = (last_gnt_q == C0);
      end else begin
        gnt0 = i_c0_req;
        gnt1 = i_c1_req;
      end
    end
  end

  // Next-state logic for the lock FSM, fairness pointer and response tag.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB: begin
        if (gnt0) last_gnt_d = C0;
        if (gnt1) begin
          last_gnt_d = C1;
          if (i_c1_lock) begin
            state_d     = LOCK1;
            burst_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCK1: begin
        // Leaving the burst always hands the next conflict to port 0.
        if (!i_c1_req || !i_c1_lock || (gnt1 && (burst_cnt_q == CNT_LAST))) begin
          state_d     = ARB;
          burst_cnt_d = '0;
          last_gnt_d  = C1;
        end else if (gnt1) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          last_gnt_d  = C1;
        end
      end
      default: begin
        state_d     = ARB;
        burst_cnt_d = '0;
      end
    endcase

    rsp_valid_d = (gnt0 && !i_c0_we) || (gnt1 && !i_c1_we);
    rsp_id_d    = rsp_valid_d ? (gnt1 ? C1 : C0) : rsp_id_q;
  end

  // State registers; reset also kills any read still in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ARB;
      last_gnt_q  <= C1;
      burst_cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= C0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Memory bus carries the winner's fields, all-zero when idle.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (gnt0) begin
      o_mem_we    = i_c0_we;
      o_mem_addr  = i_c0_addr;
      o_mem_wdata = i_c0_wdata;
    end else if (gnt1) begin
      o_mem_we    = i_c1_we;
      o_mem_addr  = i_c1_addr;
      o_mem_wdata = i_c1_wdata;
    end
  end

  assign o_c0_gnt    = gnt0;
  assign o_c1_gnt    = gnt1;
  // Stall is held low during reset so every non-grant output is quiet.
  assign o_c0_stall  = i_c0_req && !gnt0 && !i_rst;
  assign o_c0_rvalid = rsp_valid_q && (rsp_id_q == C0);
  assign o_c1_rvalid = rsp_valid_q && (rsp_id_q == C1);
  assign o_c0_rdata  = o_c0_rvalid ? i_mem_rdata : '0;
  assign o_c1_rdata  = o_c1_rvalid ? i_mem_rdata : '0;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  // cycle entry: chk_st, st, g0, g1, stall, we, addr, wdata
  localparam int EW = 6 + AW + DW;
  // response entry: due cycle, port, data
  localparam int RW = 32 + 1 + DW;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          c0_req = 0, c0_we = 0, c1_req = 0, c1_we = 0, c1_lock = 0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
  logic          o_c0_gnt, o_c0_stall, o_c0_rvalid, o_c1_gnt, o_c1_rvalid, o_mem_we;
  logic [DW-1:0] o_c0_rdata, o_c1_rdata, o_mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] o_mem_addr;
  arb_state_e    dbg_state;

  logic [DW-1:0] mem [256];
  logic [255:0]  mem_seen = '0;
  logic [DW-1:0] ref_mem [256];
  logic [255:0]  ref_seen = '0;

  logic [EW-1:0] exp_q[$];
  logic [RW-1:0] rsp_q[$];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_miss = 0;

  dmem_arbiter dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_c0_req(c0_req), .i_c0_we(c0_we), .i_c0_addr(c0_addr), .i_c0_wdata(c0_wdata),
    .o_c0_gnt(o_c0_gnt), .o_c0_stall(o_c0_stall), .o_c0_rvalid(o_c0_rvalid), .o_c0_rdata(o_c0_rdata),
    .i_c1_req(c1_req), .i_c1_we(c1_we), .i_c1_addr(c1_addr), .i_c1_wdata(c1_wdata), .i_c1_lock(c1_lock),
    .o_c1_gnt(o_c1_gnt), .o_c1_rvalid(o_c1_rvalid), .o_c1_rdata(o_c1_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
  );

  // clock / reset-free cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory: unwritten words read back their own address
  always @(posedge clk) begin
    if (o_mem_we) begin
      mem[o_mem_addr]      <= o_mem_wdata;
      mem_seen[o_mem_addr] <= 1'b1;
    end
    mem_rdata <= mem_seen[o_mem_addr] ? mem[o_mem_addr] : DW'(o_mem_addr);
  end

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
    return ref_seen[a] ? ref_mem[a] : DW'(a);
  endfunction

  // driver: one cycle of port inputs plus the hand-computed outcome
  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic lk, input logic eg0, input logic eg1, input logic er,
                       input logic cs, input logic es);
    logic          mw;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    @(posedge clk); #1;
    c0_req = r0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
    c1_req = r1; c1_we = w1; c1_addr = a1; c1_wdata = d1; c1_lock = lk;
    mw = 1'b0; ma = '0; md = '0;
    if (eg0) begin mw = w0; ma = a0; md = d0; end
    else if (eg1) begin mw = w1; ma = a1; md = d1; end
    exp_q.push_back({cs, es, eg0, eg1, r0 & ~eg0, mw, ma, md});
    if (er && eg0 && !w0) rsp_q.push_back({32'(cyc + 1), C0, ref_word(a0)});
    if (er && eg1 && !w1) rsp_q.push_back({32'(cyc + 1), C1, ref_word(a1)});
    if (eg0 && w0) begin ref_mem[a0] = d0; ref_seen[a0] = 1'b1; end
    if (eg1 && w1) begin ref_mem[a1] = d1; ref_seen[a1] = 1'b1; end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ARB);
  endtask

  // one reset cycle with both ports requesting: nothing may be granted
  task automatic reset_cycle();
    @(posedge clk); #1;
    i_rst = 1'b1;
    c0_req = 1; c0_we = 0; c0_addr = 8'd3; c0_wdata = '0;
    c1_req = 1; c1_we = 1; c1_addr = 8'd4; c1_wdata = 32'd5; c1_lock = 1;
    exp_q.push_back({1'b1, ARB, 4'b0, {AW{1'b0}}, {DW{1'b0}}});
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0; c1_lock = 0;
    i_rst = 1'b0;
  endtask

  // scoreboard monitor, samples on the falling edge
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [RW-1:0] r;
    logic [2*DW+1:0] got_rsp, want_rsp;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({o_c0_gnt, o_c1_gnt, o_c0_stall} !== e[EW-3:EW-5]) begin
        n_miss++;
        $display("FAIL grant cyc=%0d g0/g1/stall got=%b want=%b", cyc,
                 {o_c0_gnt, o_c1_gnt, o_c0_stall}, e[EW-3:EW-5]);
      end
      n_vec++;
      if ({o_mem_we, o_mem_addr, o_mem_wdata} !== e[AW+DW:0]) begin
        n_miss++;
        $display("FAIL membus cyc=%0d we/addr/wdata got=%b/%0d/%h want=%b/%0d/%h", cyc,
                 o_mem_we, o_mem_addr, o_mem_wdata, e[AW+DW], e[AW+DW-1:DW], e[DW-1:0]);
      end
      if (e[EW-1]) begin
        n_vec++;
        if (dbg_state !== e[EW-2]) begin
          n_miss++;
          $display("FAIL state cyc=%0d got=%b want=%b", cyc, dbg_state, e[EW-2]);
        end
      end
    end
    if (rsp_q.size() > 0 && rsp_q[0][RW-1:DW+1] == 32'(cyc)) begin
      r = rsp_q.pop_front();
      got_rsp  = {o_c0_rvalid, o_c1_rvalid, o_c0_rdata, o_c1_rdata};
      want_rsp = (r[DW] == C0) ? {2'b10, r[DW-1:0], {DW{1'b0}}} : {2'b01, {DW{1'b0}}, r[DW-1:0]};
      n_vec++;
      if (got_rsp !== want_rsp) begin
        n_miss++;
        $display("FAIL rsp cyc=%0d rv0/rv1/rd0/rd1 got=%b%b/%h/%h want=%b/%h/%h", cyc,
                 o_c0_rvalid, o_c1_rvalid, o_c0_rdata, o_c1_rdata,
                 want_rsp[2*DW+1:2*DW], want_rsp[2*DW-1:DW], want_rsp[DW-1:0]);
      end
    end else if (o_c0_rvalid || o_c1_rvalid) begin
      n_vec++;
      n_miss++;
      $display("FAIL spurious_rvalid cyc=%0d rv0=%b rv1=%b want 0/0", cyc, o_c0_rvalid, o_c1_rvalid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // directed test sequence
  initial begin
    reset_cycle(); reset_cycle(); release_reset();

    // port 0 alone reads addr 25
    drive(1, 0, 8'd25, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, ARB);
    idle();

    // fresh reset, then simultaneous c0 write / c1 read
    reset_cycle(); release_reset();
    drive(1, 1, 8'd100, 32'd25, 1, 0, 8'd96, 0, 0, 1, 0, 1, 0, ARB);
    drive(0, 0, 0, 0, 1, 0, 8'd96, 0, 0, 0, 1, 1, 0, ARB);
    idle();

    // six cycles of conflict, no lock: strict alternation starting with c0
    for (int k = 0; k < 6; k++)
      drive(1, 0, 8'(10 + (k + 1) / 2), 0, 1, 0, 8'(50 + k / 2), 0, 0,
            (k % 2) == 0, (k % 2) == 1, 1, 0, ARB);
    idle();

    // locked burst of four, c0 stalled, then c0 wins
    drive(1, 0, 8'd7, 0, 1, 1, 8'd200, 32'hA0, 1, 1, 0, 1, 1, ARB);
    drive(1, 0, 8'd8, 0, 1, 1, 8'd200, 32'hA0, 1, 0, 1, 1, 1, ARB);
    drive(1, 0, 8'd8, 0, 1, 1, 8'd201, 32'hA1, 1, 0, 1, 1, 1, LOCK1);
    drive(1, 0, 8'd8, 0, 1, 1, 8'd202, 32'hA2, 1, 0, 1, 1, 1, LOCK1);
    drive(1, 0, 8'd8, 0, 1, 1, 8'd203, 32'hA3, 1, 0, 1, 1, 1, LOCK1);
    drive(1, 0, 8'd8, 0, 1, 1, 8'd204, 32'hA4, 1, 1, 0, 1, 1, ARB);

    // lock dropped after two grants: exit grant, then c0 reads back 200
    drive(1, 0, 8'd200, 0, 1, 1, 8'd210, 32'hB0, 1, 0, 1, 1, 1, ARB);
    drive(1, 0, 8'd200, 0, 1, 1, 8'd211, 32'hB1, 1, 0, 1, 1, 1, LOCK1);
    drive(1, 0, 8'd200, 0, 1, 1, 8'd212, 32'hB2, 0, 0, 1, 1, 1, LOCK1);
    drive(1, 0, 8'd200, 0, 1, 1, 8'd213, 32'hB3, 0, 1, 0, 1, 1, ARB);
    idle();

    // lock exits when c1 stops requesting; c0 then wins the conflict
    drive(0, 0, 0, 0, 1, 0, 8'd204, 0, 1, 0, 1, 1, 1, ARB);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, LOCK1);
    drive(1, 0, 8'd1, 0, 1, 0, 8'd2, 0, 0, 1, 0, 1, 1, ARB);
    idle();

    // reset right after a granted c1 read: its response must vanish
    drive(0, 0, 0, 0, 1, 0, 8'd30, 0, 0, 0, 1, 0, 1, ARB);
    reset_cycle(); reset_cycle(); release_reset();
    drive(1, 0, 8'd40, 0, 1, 0, 8'd41, 0, 0, 1, 0, 1, 1, ARB);
    idle(); idle(); idle();

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
